// File: rtl/dds_voice_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : dds_voice_bank_if
//  Description : Configuration-write and sample-output bundle for the
//                multi-voice DDS engine. The master side writes voice
//                registers and receives mixed samples. The slave side is
//                the engine itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface dds_voice_bank_if #(
    parameter int VOICES = 4,
    parameter int TUNE_W = 16,
    parameter int WAVE_W = 12
);
    localparam int c_ADDR_W = $clog2(VOICES) + 2;

    logic                wr_en;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [TUNE_W-1:0]   wr_data;
    logic [WAVE_W-1:0]   sample_out;
    logic                sample_valid;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  sample_out,
        input  sample_valid
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output sample_out,
        output sample_valid
    );
endinterface
`default_nettype wire

// File: rtl/dds_voice_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dds_voice_bank
//  Description : Time-multiplexed N-voice DDS engine. One phase/waveform
//                datapath visits every voice once per sample tick. The
//                voice outputs (saw, pulse, triangle, noise) are summed and
//                scaled down by the voice count. The result is emitted with
//                a one-cycle valid strobe that doubles as the DAC load pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_voice_bank #(
    parameter int VOICES = 4,
    parameter int TUNE_W = 16,
    parameter int WAVE_W = 12,
    parameter int DIV    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dds_voice_bank_if.slave   bus
);
    localparam int c_VI_W  = $clog2(VOICES);
    localparam int c_TC_W  = $clog2(DIV);
    localparam int c_SUM_W = WAVE_W + c_VI_W;

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_RUN  = 2'd1;
    localparam logic [1:0]  c_ST_DONE = 2'd2;
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    // ------------------------------------------------------------------
    // Per-voice state
    // ------------------------------------------------------------------
    logic [TUNE_W-1:0] r_acc  [VOICES];
    logic [TUNE_W-1:0] r_tune [VOICES];
    logic [2:0]        r_ctrl [VOICES];
    logic [WAVE_W-1:0] r_pw   [VOICES];

    // ------------------------------------------------------------------
    // Shared sequencing / datapath state
    // ------------------------------------------------------------------
    logic [c_TC_W-1:0]  r_tc;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_VI_W-1:0]  r_vi;
    logic [c_SUM_W-1:0] r_sum;
    logic [15:0]        r_lfsr;
    logic [WAVE_W-1:0]  r_sample;
    logic               r_valid;

    logic               w_tick;
    logic               w_start;
    logic               w_run;
    logic               w_done;
    logic [1:0]         w_wr_field;
    logic [c_VI_W-1:0]  w_wr_voice;
    logic [TUNE_W-1:0]  w_acc_cur;
    logic [2:0]         w_ctrl;
    logic [WAVE_W-1:0]  w_p;
    logic [WAVE_W-1:0]  w_tri_up;
    logic [WAVE_W-1:0]  w_wave;
    logic [WAVE_W-1:0]  w_contrib;
    logic               w_lfsr_fb;

    assign w_tick     = (r_tc == c_TC_W'(DIV - 1));
    assign w_wr_field = bus.wr_addr[1:0];
    assign w_wr_voice = bus.wr_addr[c_VI_W+1:2];

    // Sample-rate divider: free-running 0..DIV-1, the tick is its last count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= '0;
        end else if (w_tick) begin
            r_tc <= '0;
        end else begin
            r_tc <= r_tc + 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next-state and phase strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = c_ST_RUN;
                    w_start     = 1'b1;
                end
            end
            c_ST_RUN: begin
                w_run = 1'b1;
                if (r_vi == c_VI_W'(VOICES - 1)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // The voice being visited this cycle; phase is sampled before its update
    assign w_acc_cur = r_acc[r_vi];
    assign w_ctrl    = r_ctrl[r_vi];
    assign w_p       = w_acc_cur[TUNE_W-1 -: WAVE_W];
    assign w_tri_up  = {w_p[WAVE_W-2:0], 1'b0};

    // Waveform shaping of the current voice's phase
    always_comb begin
        w_wave = '0;
        case (w_ctrl[1:0])
            2'd0:    w_wave = w_p;
            2'd1:    w_wave = (w_p < r_pw[r_vi]) ? '1 : '0;
            2'd2:    w_wave = w_p[WAVE_W-1] ? ~w_tri_up : w_tri_up;
            default: w_wave = r_lfsr[15 -: WAVE_W];
        endcase
    end

    // Disabled voices are silent
    assign w_contrib = w_ctrl[2] ? w_wave : '0;

    // Voice index and running sum across the RUN window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vi  <= '0;
            r_sum <= '0;
        end else if (w_start) begin
            r_vi  <= '0;
            r_sum <= '0;
        end else if (w_run) begin
            r_vi  <= r_vi + 1'b1;
            r_sum <= r_sum + c_SUM_W'(w_contrib);
        end
    end

    // Taps 16/14/13/11 expressed on a right-shifting register
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Noise source advances once per sample, shared by every voice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_done) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Output register: the top bits of the sum are the average of the voices
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_sample <= r_sum[c_SUM_W-1 -: WAVE_W];
            end
        end
    end

    assign bus.sample_out   = r_sample;
    assign bus.sample_valid = r_valid;

    // ------------------------------------------------------------------
    // Per-voice register file and phase accumulator
    // ------------------------------------------------------------------
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic w_hit;
        assign w_hit = bus.wr_en && (w_wr_voice == c_VI_W'(v));

        // Configuration fields; the datapath reads the pre-write values
        always_ff @(posedge clk) begin
            if (rst) begin
                r_tune[v] <= '0;
                r_ctrl[v] <= '0;
                r_pw[v]   <= '0;
            end else if (w_hit) begin
                case (w_wr_field)
                    2'd0:    r_tune[v] <= bus.wr_data;
                    2'd1:    r_ctrl[v] <= bus.wr_data[2:0];
                    2'd2:    r_pw[v]   <= bus.wr_data[WAVE_W-1:0];
                    default: ;
                endcase
            end
        end

        // Phase accumulator; a phase-reset write wins over the accumulate
        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc[v] <= '0;
            end else if (w_hit && (w_wr_field == 2'd3)) begin
                r_acc[v] <= '0;
            end else if (w_run && (r_vi == c_VI_W'(v)) && r_ctrl[v][2]) begin
                r_acc[v] <= r_acc[v] + r_tune[v];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_voice_bank
//  Description : Directed self-checking bench for dds_voice_bank
//                (4 voices, 16-bit tune, 12-bit wave, DIV=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dds_voice_bank;
    localparam int VOICES = 4;
    localparam int TUNE_W = 16;
    localparam int WAVE_W = 12;
    localparam int DIV    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    dds_voice_bank_if #(.VOICES(VOICES), .TUNE_W(TUNE_W), .WAVE_W(WAVE_W)) bus ();

    dds_voice_bank #(
        .VOICES(VOICES),
        .TUNE_W(TUNE_W),
        .WAVE_W(WAVE_W),
        .DIV   (DIV)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold reset for three clocks, release just after an edge
    task automatic do_reset();
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One-cycle register write
    task automatic wr(input int voice, input int field, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'((voice << 2) | field);
        bus.wr_data = data;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    // Wait (bounded) for the next valid strobe and return the sample
    task automatic wait_valid(output logic [11:0] s);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (bus.sample_valid !== 1'b1 && k < 4 * DIV);
        check("valid_seen", 32'(bus.sample_valid), 32'd1);
        s = bus.sample_out;
    endtask

    task automatic expect_sample(input string tag, input logic [11:0] exp);
        logic [11:0] s;
        wait_valid(s);
        check(tag, 32'(s), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        logic [11:0] pulse_pat [4];
        logic [11:0] tri_pat   [4];
        logic [11:0] noise_pat [3];
        pulse_pat = '{12'h3FF, 12'h3FF, 12'h000, 12'h000};
        tri_pat   = '{12'h000, 12'h200, 12'h3FF, 12'h1FF};
        noise_pat = '{12'h2B3, 12'h159, 12'h2AC};

        // ---------------- reset and strobe cadence ----------------
        do_reset();
        check("rst_out", 32'(bus.sample_out), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        for (int n = 1; n <= 29; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("cad_valid_%0d", n), 32'(bus.sample_valid),
                  32'((n == 13) || (n == 21) || (n == 29)));
            check($sformatf("cad_out_%0d", n), 32'(bus.sample_out), 32'd0);
        end

        // ---------------- reset mid-RUN aborts the sample ----------------
        do_reset();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 11; n <= 23; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_valid_%0d", n), 32'(bus.sample_valid), 32'(n == 23));
        end

        // ---------------- saw on voice 0 ----------------
        do_reset();
        wr(0, 0, 16'h1000);
        wr(0, 1, 16'h0004);
        for (int k = 0; k <= 16; k++) begin
            expect_sample($sformatf("saw_%0d", k), 12'((k % 16) * 'h40));
        end

        // ---------------- pulse on voice 1 ----------------
        do_reset();
        wr(1, 0, 16'h4000);
        wr(1, 2, 16'h0800);
        wr(1, 1, 16'h0005);
        for (int k = 0; k < 8; k++) begin
            expect_sample($sformatf("pulse_%0d", k), pulse_pat[k % 4]);
        end

        // ---------------- triangle on voice 2 ----------------
        do_reset();
        wr(2, 0, 16'h4000);
        wr(2, 1, 16'h0006);
        for (int k = 0; k < 8; k++) begin
            expect_sample($sformatf("tri_%0d", k), tri_pat[k % 4]);
        end

        // ---------------- noise on voice 0 (seed 0xACE1) ----------------
        do_reset();
        wr(0, 1, 16'h0007);
        for (int k = 0; k < 3; k++) begin
            expect_sample($sformatf("noise_%0d", k), noise_pat[k]);
        end

        // ---------------- four-voice mix with phase reset ----------------
        do_reset();
        for (int v = 0; v < 4; v++) wr(v, 0, 16'h1000);
        for (int v = 0; v < 4; v++) wr(v, 1, 16'h0004);
        expect_sample("mix_pre0", 12'h000);
        expect_sample("mix_pre1", 12'h100);
        for (int v = 0; v < 4; v++) wr(v, 3, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            expect_sample($sformatf("mix4_%0d", k), 12'(k * 'h100));
        end
        wr(3, 1, 16'h0000);
        for (int k = 3; k < 7; k++) begin
            expect_sample($sformatf("mix3_%0d", k), 12'((3 * k * 'h100) >> 2));
        end

        // ---------------- write collision with voice 0 processing ----------------
        do_reset();
        wr(0, 0, 16'h1000);
        wr(0, 1, 16'h0004);
        expect_sample("col_s0", 12'h000);
        expect_sample("col_s1", 12'h040);
        repeat (3) @(posedge clk);
        #1;
        wr(0, 0, 16'h2000);
        expect_sample("col_s2", 12'h080);
        expect_sample("col_s3", 12'h0C0);
        expect_sample("col_s4", 12'h140);
        repeat (3) @(posedge clk);
        #1;
        wr(0, 3, 16'h0000);
        expect_sample("col_s5", 12'h1C0);
        expect_sample("col_s6", 12'h000);
        expect_sample("col_s7", 12'h080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
